// File: rtl/mandel_dispatcher_if.sv
// Engine fan-out bus and raster-ordered pixel stream of the Mandelbrot dispatcher.
// master = dispatcher side, slave = engines plus the colour-mapping consumer.
interface mandel_dispatcher_if #(
    parameter int N_ENGINES   = 4,
    parameter int WORD_LENGTH = 16
);
    logic [N_ENGINES-1:0]             eng_start;
    logic [N_ENGINES*WORD_LENGTH-1:0] eng_re_c;
    logic [N_ENGINES*WORD_LENGTH-1:0] eng_im_c;
    logic [9:0]                       eng_max_iter;
    logic [N_ENGINES-1:0]             eng_done;
    logic [N_ENGINES*10-1:0]          eng_depth;
    logic                             pix_valid;
    logic                             pix_ready;
    logic [9:0]                       pix_depth;
    logic [9:0]                       pix_x;
    logic [8:0]                       pix_y;
    logic                             pix_sof;
    logic                             pix_eol;

    modport master (
        output eng_start, eng_re_c, eng_im_c, eng_max_iter,
        input  eng_done, eng_depth,
        output pix_valid, pix_depth, pix_x, pix_y, pix_sof, pix_eol,
        input  pix_ready
    );

    modport slave (
        input  eng_start, eng_re_c, eng_im_c, eng_max_iter,
        output eng_done, eng_depth,
        input  pix_valid, pix_depth, pix_x, pix_y, pix_sof, pix_eol,
        output pix_ready
    );
endinterface

// File: rtl/mandel_dispatcher.sv
// Raster-walks a frame, issues pixel constants round-robin to depth engines and
// collects depths back in raster order; 1-cycle done-to-valid, stalls hold on !pix_ready.
module mandel_dispatcher #(
    parameter int N_ENGINES   = 4,
    parameter int WORD_LENGTH = 16,
    parameter int FRAC        = 8,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [WORD_LENGTH-1:0] re_origin,
    input  logic [WORD_LENGTH-1:0] im_origin,
    input  logic [WORD_LENGTH-1:0] step,
    input  logic [9:0]             max_iter_in,
    output logic                   busy,
    output logic                   frame_done,
    mandel_dispatcher_if.master    bus
);
    localparam int WL = WORD_LENGTH;
    localparam int IW = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [1:0] S_FREE  = 2'd0;
    localparam logic [1:0] S_GUARD = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    if (N_ENGINES < 1 || FRAC >= WORD_LENGTH) begin : g_bad_param
        $error("mandel_dispatcher: invalid N_ENGINES or FRAC");
    end

    logic [0:0]    state;
    logic [WL-1:0] org_re;
    logic [WL-1:0] step_r;
    logic [9:0]    max_iter_r;

    logic [9:0]    gen_x;
    logic [8:0]    gen_y;
    logic [WL-1:0] acc_re;
    logic [WL-1:0] acc_im;
    logic          exhausted;

    logic [IW-1:0] ip;
    logic [IW-1:0] cp;
    logic [N_ENGINES-1:0] start_r;

    logic [1:0]    slot_st    [N_ENGINES];
    logic [WL-1:0] slot_re    [N_ENGINES];
    logic [WL-1:0] slot_im    [N_ENGINES];
    logic [9:0]    slot_x     [N_ENGINES];
    logic [8:0]    slot_y     [N_ENGINES];
    logic [9:0]    slot_depth [N_ENGINES];

    // The frame_start edge itself issues pixel (0,0) straight from the inputs, so
    // the first start pulse lands one cycle after frame_start with c already registered.
    logic          start_now;
    logic          issue;
    logic          last_gen;
    logic          accept;
    logic          last_acc;
    logic [9:0]    cur_x;
    logic [8:0]    cur_y;
    logic [WL-1:0] cur_re;
    logic [WL-1:0] cur_im;
    logic [WL-1:0] cur_step;
    logic [WL-1:0] cur_org;
    logic [IW-1:0] ip_next;
    logic [IW-1:0] cp_next;

    always_comb begin
        start_now = (state == IDLE) && frame_start;
        cur_x     = start_now ? 10'd0 : gen_x;
        cur_y     = start_now ? 9'd0 : gen_y;
        cur_re    = start_now ? re_origin : acc_re;
        cur_im    = start_now ? im_origin : acc_im;
        cur_step  = start_now ? step : step_r;
        cur_org   = start_now ? re_origin : org_re;
        issue     = (start_now || (state == RUN && !exhausted)) && (slot_st[ip] == S_FREE);
        last_gen  = (cur_x == 10'(H_RES - 1)) && (cur_y == 9'(V_RES - 1));
        accept    = bus.pix_valid && bus.pix_ready;
        last_acc  = accept && (slot_x[cp] == 10'(H_RES - 1)) && (slot_y[cp] == 9'(V_RES - 1));
        ip_next   = (ip == IW'(N_ENGINES - 1)) ? '0 : ip + 1'b1;
        cp_next   = (cp == IW'(N_ENGINES - 1)) ? '0 : cp + 1'b1;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state      <= IDLE;
            frame_done <= 1'b0;
            org_re     <= '0;
            step_r     <= '0;
            max_iter_r <= '0;
            gen_x      <= '0;
            gen_y      <= '0;
            acc_re     <= '0;
            acc_im     <= '0;
            exhausted  <= 1'b0;
            ip         <= '0;
            cp         <= '0;
            start_r    <= '0;
            for (int i = 0; i < N_ENGINES; i++) begin
                slot_st[i]    <= S_FREE;
                slot_re[i]    <= '0;
                slot_im[i]    <= '0;
                slot_x[i]     <= '0;
                slot_y[i]     <= '0;
                slot_depth[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            start_r    <= '0;

            if (start_now) begin
                state      <= RUN;
                org_re     <= re_origin;
                step_r     <= step;
                max_iter_r <= max_iter_in;
                exhausted  <= 1'b0;
            end else if (last_acc) begin
                state      <= IDLE;
                frame_done <= 1'b1;
            end

            // Engines hold done as a level that is stale until they see start, hence GUARD.
            for (int i = 0; i < N_ENGINES; i++) begin
                case (slot_st[i])
                    S_GUARD: slot_st[i] <= S_BUSY;
                    S_BUSY: begin
                        if (bus.eng_done[i]) begin
                            slot_st[i]    <= S_FULL;
                            slot_depth[i] <= bus.eng_depth[i*10 +: 10];
                        end
                    end
                    S_FULL: begin
                        if (accept && (cp == IW'(i))) slot_st[i] <= S_FREE;
                    end
                    default: ;
                endcase
            end
            if (accept) cp <= cp_next;

            if (issue) begin
                start_r[ip] <= 1'b1;
                slot_st[ip] <= S_GUARD;
                slot_re[ip] <= cur_re;
                slot_im[ip] <= cur_im;
                slot_x[ip]  <= cur_x;
                slot_y[ip]  <= cur_y;
                ip          <= ip_next;
                if (last_gen) exhausted <= 1'b1;
                if (cur_x == 10'(H_RES - 1)) begin
                    gen_x  <= '0;
                    gen_y  <= cur_y + 9'd1;
                    acc_re <= cur_org;
                    acc_im <= cur_im - cur_step;
                end else begin
                    gen_x  <= cur_x + 10'd1;
                    gen_y  <= cur_y;
                    acc_re <= cur_re + cur_step;
                    acc_im <= cur_im;
                end
            end
        end
    end

    always_comb begin
        busy             = (state == RUN);
        bus.eng_start    = start_r;
        bus.eng_max_iter = max_iter_r;
        bus.eng_re_c     = '0;
        bus.eng_im_c     = '0;
        for (int i = 0; i < N_ENGINES; i++) begin
            bus.eng_re_c[i*WL +: WL] = slot_re[i];
            bus.eng_im_c[i*WL +: WL] = slot_im[i];
        end
        bus.pix_valid = (slot_st[cp] == S_FULL);
        bus.pix_depth = slot_depth[cp];
        bus.pix_x     = slot_x[cp];
        bus.pix_y     = slot_y[cp];
        bus.pix_sof   = bus.pix_valid && (slot_x[cp] == 10'd0) && (slot_y[cp] == 9'd0);
        bus.pix_eol   = bus.pix_valid && (slot_x[cp] == 10'(H_RES - 1));
    end
endmodule

// File: tb/tb_mandel_dispatcher.sv
// Drives small 4x2 frames through a 2-engine dispatcher with latency-programmable
// engine models and checks every issued c and every output pixel against arithmetic.
module tb_mandel_dispatcher;
    localparam int N = 2, WL = 16, H = 4, V = 2, NPIX = H * V;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] re_origin = '0, im_origin = '0, step = '0;
    logic [9:0]  max_iter_in = '0;
    logic        busy, frame_done;

    mandel_dispatcher_if #(.N_ENGINES(N), .WORD_LENGTH(WL)) bus ();

    mandel_dispatcher #(.N_ENGINES(N), .WORD_LENGTH(WL), .FRAC(8), .H_RES(H), .V_RES(V)) dut (
        .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
        .re_origin(re_origin), .im_origin(im_origin), .step(step),
        .max_iter_in(max_iter_in), .busy(busy), .frame_done(frame_done), .bus(bus)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [15:0] re, im, st;
        logic [9:0]  cap;
        int          l0, l1;
        int          rmode;     // 0 always ready, 1 toggle, 2 random
        bit          dmode;     // depth = cap - index instead of index
        bit          stale;     // engines hold done=1 out of reset
        bit          inject;    // extra frame_start while running
        bit          has_c11;
        logic [15:0] c11_re, c11_im;
        logic [9:0]  first_depth;
    } vec_t;

    int checks = 0, failures = 0;

    // frame configuration seen by the engine/monitor process
    logic [15:0] c_re, c_im, c_step, c_11re, c_11im;
    logic [9:0]  c_cap, c_first;
    bit          c_dmode, c_has11, stale;
    int          lat[N];
    int          rmode;

    // owned by the engine/monitor process only
    int          cnt[N];
    logic [9:0]  val[N];
    int          k, out_n, fd_cnt;
    bit          prev_stall;
    logic [31:0] prev_fields;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [9:0] exp_depth(input int n);
        return c_dmode ? (c_cap - 10'(n)) : 10'(n);
    endfunction

    function automatic logic [15:0] exp_re(input int n);
        logic [15:0] x = 16'(n % H);
        return c_re + x * c_step;
    endfunction

    function automatic logic [15:0] exp_im(input int n);
        logic [15:0] y = 16'(n / H);
        return c_im - y * c_step;
    endfunction

    function automatic logic [31:0] fields();
        return {bus.pix_valid, bus.pix_depth, bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol};
    endfunction

    always @(negedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] = 0;
                bus.eng_done[i] = stale;
                bus.eng_depth[i*10 +: 10] = 10'h155;
            end
            k = 0; out_n = 0; fd_cnt = 0; prev_stall = 0;
            bus.pix_ready = 1'b0;
        end else begin
            if (frame_done) begin
                fd_cnt++;
                chk("done_after_last", 64'(out_n % NPIX), 0);
            end
            if (prev_stall) chk("stall_hold", fields(), prev_fields);
            if (busy) chk("max_iter_hold", bus.eng_max_iter, c_cap);

            for (int i = 0; i < N; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        bus.eng_done[i] = 1'b1;
                        bus.eng_depth[i*10 +: 10] = val[i];
                    end else begin
                        bus.eng_done[i] = 1'b0;
                    end
                end
                if (bus.eng_start[i]) begin
                    chk("issue_re", bus.eng_re_c[i*WL +: WL], exp_re(k % NPIX));
                    chk("issue_im", bus.eng_im_c[i*WL +: WL], exp_im(k % NPIX));
                    if (c_has11 && (k % NPIX) == 5) begin
                        chk("c11_re", bus.eng_re_c[i*WL +: WL], c_11re);
                        chk("c11_im", bus.eng_im_c[i*WL +: WL], c_11im);
                    end
                    val[i] = exp_depth(k % NPIX);
                    k++;
                    cnt[i] = lat[i] + 1;
                end
            end

            case (rmode)
                0:       bus.pix_ready = 1'b1;
                1:       bus.pix_ready = ~bus.pix_ready;
                default: bus.pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (bus.pix_valid && bus.pix_ready) begin
                chk("pix_x", bus.pix_x, 64'((out_n % NPIX) % H));
                chk("pix_y", bus.pix_y, 64'((out_n % NPIX) / H));
                chk("pix_depth", bus.pix_depth, exp_depth(out_n % NPIX));
                chk("pix_sof", bus.pix_sof, 64'((out_n % NPIX) == 0));
                chk("pix_eol", bus.pix_eol, 64'(((out_n % NPIX) % H) == H - 1));
                if ((out_n % NPIX) == 0) chk("first_depth", bus.pix_depth, c_first);
                out_n++;
                prev_stall = 0;
            end else begin
                prev_stall = bus.pix_valid;
            end
            prev_fields = fields();
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_eng_start"}, bus.eng_start, 0);
        chk({tag, "_pix_valid"}, bus.pix_valid, 0);
        chk({tag, "_sof_eol"}, {bus.pix_sof, bus.pix_eol}, 0);
        chk({tag, "_eng_c"}, {bus.eng_re_c, bus.eng_im_c}, 0);
        chk({tag, "_eng_max_iter"}, bus.eng_max_iter, 0);
        chk({tag, "_pix_fields"}, {bus.pix_depth, bus.pix_x, bus.pix_y}, 0);
    endtask

    task automatic load_cfg(input vec_t v);
        c_re = v.re; c_im = v.im; c_step = v.st; c_cap = v.cap;
        c_dmode = v.dmode; c_has11 = v.has_c11; c_11re = v.c11_re; c_11im = v.c11_im;
        c_first = v.first_depth; lat[0] = v.l0; lat[1] = v.l1; rmode = v.rmode;
    endtask

    task automatic start_frame(input vec_t v);
        @(negedge sysclk);
        re_origin = v.re; im_origin = v.im; step = v.st; max_iter_in = v.cap;
        frame_start = 1'b1;
        @(negedge sysclk);
        frame_start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("first_start", bus.eng_start, 1);
        // origin inputs are latched; scribble them to prove it
        re_origin = 16'($urandom); im_origin = 16'($urandom);
        step = 16'($urandom); max_iter_in = 10'($urandom);
        @(negedge sysclk);
        chk("second_start", bus.eng_start, 2);
    endtask

    task automatic run_frame(input vec_t v);
        int n0, fd0, k0;
        load_cfg(v);
        stale = v.stale;
        if (v.stale) begin
            @(negedge sysclk);
            reset = 1'b1;
            repeat (2) @(negedge sysclk);
            reset = 1'b0;
        end
        n0 = out_n; fd0 = fd_cnt; k0 = k;
        start_frame(v);
        for (int c = 0; c < 3000; c++) begin
            @(negedge sysclk);
            frame_start = (v.inject && c == 4);
            if (fd_cnt != fd0) break;
        end
        frame_start = 1'b0;
        repeat (4) @(negedge sysclk);
        chk("frame_done_seen", 64'(fd_cnt != fd0), 1);
        chk("frame_done_pulses", 64'(fd_cnt - fd0), 1);
        chk("pixels_out", 64'(out_n - n0), NPIX);
        chk("pixels_issued", 64'(k - k0), NPIX);
        chk("busy_fall", busy, 0);
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        tbl[0] = '{16'hFE00, 16'h0100, 16'h0040, 10'd7, 5, 5, 0, 0, 0, 0, 1, 16'hFE40, 16'h00C0, 10'd0};
        tbl[1] = '{16'hFE00, 16'h0100, 16'h0040, 10'd7, 20, 3, 0, 0, 0, 0, 1, 16'hFE40, 16'h00C0, 10'd0};
        tbl[2] = '{16'h0010, 16'h0020, 16'h0001, 10'd9, 5, 5, 1, 0, 0, 0, 1, 16'h0011, 16'h001F, 10'd0};
        tbl[3] = '{16'h1234, 16'h0000, 16'h0100, 10'd50, 4, 6, 0, 1, 1, 0, 1, 16'h1334, 16'hFF00, 10'd50};
        tbl[4] = '{16'hFE00, 16'h0100, 16'h0040, 10'd7, 7, 2, 2, 0, 0, 1, 1, 16'hFE40, 16'h00C0, 10'd0};
        tbl[5] = '{16'h7FF0, 16'h8000, 16'h0010, 10'd1023, 3, 9, 1, 1, 0, 0, 1, 16'h8000, 16'h7FF0, 10'd1023};

        stale = 0;
        load_cfg(tbl[0]);
        repeat (3) @(negedge sysclk);
        check_zero("rst");
        reset = 1'b0;

        foreach (tbl[i]) run_frame(tbl[i]);

        // reset in the middle of a frame, then a clean frame
        load_cfg(tbl[1]);
        start_frame(tbl[1]);
        repeat (12) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        check_zero("midrst");
        @(negedge sysclk);
        reset = 1'b0;
        run_frame(tbl[0]);

        for (int r = 0; r < 4; r++) begin
            rv.re = 16'($urandom); rv.im = 16'($urandom); rv.st = 16'($urandom_range(1, 16'hFFFF));
            rv.cap = 10'($urandom); rv.l0 = $urandom_range(1, 25); rv.l1 = $urandom_range(1, 25);
            rv.rmode = 2; rv.dmode = 1'($urandom_range(0, 1)); rv.stale = 0; rv.inject = 1;
            rv.has_c11 = 0; rv.c11_re = '0; rv.c11_im = '0;
            rv.first_depth = rv.dmode ? rv.cap : 10'd0;
            run_frame(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
